// File: rtl/wb_free_arbiter.sv
// Writeback free-request arbiter: four per-source FIFOs drained onto two
// busy-table free ports by a round-robin arbiter, flushed on ROB rollback.
module wb_free_arbiter #(
    parameter int         PREG_W             = 6,
    parameter int         FIFO_DEPTH         = 2,
    parameter logic [1:0] ROB_STATE_ROLLBACK = 2'd1
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [3:0]                           src_valid,
    input  logic [4*PREG_W-1:0]                  src_prd,
    output logic [3:0]                           src_ready,
    input  logic [1:0]                           rob_state,
    output logic                                 free0_en,
    output logic [PREG_W-1:0]                    free0_rd,
    output logic                                 free1_en,
    output logic [PREG_W-1:0]                    free1_rd,
    output logic [$clog2(4*FIFO_DEPTH+1)-1:0]    pending_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PEND_W = $clog2(4*FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [PREG_W-1:0] mem    [4][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [4];
    logic [PTR_W-1:0]  wr_ptr [4];
    logic [CNT_W-1:0]  count  [4];
    logic [1:0]        rr_ptr;

    logic       rollback;
    logic [3:0] nonempty;
    logic [3:0] push;
    logic [3:0] pop;
    logic       g0_v;
    logic       g1_v;
    logic [1:0] g0_idx;
    logic [1:0] g1_idx;
    logic [1:0] idx;

    always_comb begin
        rollback = (rob_state == ROB_STATE_ROLLBACK);
        for (int i = 0; i < 4; i++) begin
            nonempty[i]  = (count[i] != '0);
            src_ready[i] = (count[i] != FULL) & ~rollback;
            push[i]      = src_valid[i] & src_ready[i];
        end
    end

    // Walk the four sources starting at rr_ptr; first two non-empty win.
    always_comb begin
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = 2'd0;
        g1_idx = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (nonempty[idx] && !rollback) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = idx;
                end else if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = idx;
                end
            end
        end
        pop = 4'b0000;
        if (g0_v) pop[g0_idx] = 1'b1;
        if (g1_v) pop[g1_idx] = 1'b1;
    end

    always_comb begin
        free0_en = g0_v;
        free1_en = g1_v;
        free0_rd = g0_v ? mem[g0_idx][rd_ptr[g0_idx]] : '0;
        free1_rd = g1_v ? mem[g1_idx][rd_ptr[g1_idx]] : '0;
        pending_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            pending_cnt = pending_cnt + PEND_W'(count[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= 2'd0;
        end else if (rollback) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (g1_v) begin
                rr_ptr <= g1_idx + 2'd1;
            end else if (g0_v) begin
                rr_ptr <= g0_idx + 2'd1;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= src_prd[i*PREG_W +: PREG_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 4; i++) begin
                assert (!(push[i] && count[i] == FULL));
                assert (!(pop[i] && count[i] == '0));
            end
            assert (free0_en || !free1_en);
        end
    end

endmodule

// File: tb/tb_wb_free_arbiter.sv
// Bench for wb_free_arbiter: queue-based reference scoreboard checked every
// cycle, plus directed scenario tasks with hand-derived expectations.
module tb_wb_free_arbiter;

    localparam int PREG_W     = 6;
    localparam int FIFO_DEPTH = 2;
    localparam int PEND_W     = $clog2(4*FIFO_DEPTH + 1);
    localparam logic [1:0] ROB_IDLE     = 2'd0;
    localparam logic [1:0] ROB_ROLLBACK = 2'd1;
    localparam logic [1:0] ROB_WALK     = 2'd2;

    logic                  clock;
    logic                  reset_n;
    logic [3:0]            src_valid;
    logic [4*PREG_W-1:0]   src_prd;
    logic [3:0]            src_ready;
    logic [1:0]            rob_state;
    logic                  free0_en;
    logic [PREG_W-1:0]     free0_rd;
    logic                  free1_en;
    logic [PREG_W-1:0]     free1_rd;
    logic [PEND_W-1:0]     pending_cnt;

    wb_free_arbiter #(.PREG_W(PREG_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .src_valid(src_valid), .src_prd(src_prd),
        .src_ready(src_ready), .rob_state(rob_state), .free0_en(free0_en),
        .free0_rd(free0_rd), .free1_en(free1_en), .free1_rd(free1_rd),
        .pending_cnt(pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: per-source queues of accepted prds plus a round-robin pointer.
    logic [PREG_W-1:0] sq [4][$];
    int                m_rr;

    function automatic void m_grants(output logic e0, output int s0,
                                     output logic e1, output int s1);
        e0 = 1'b0; e1 = 1'b0; s0 = 0; s1 = 0;
        if (rob_state == ROB_ROLLBACK) return;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (m_rr + k) % 4;
            if (sq[s].size() > 0) begin
                if (!e0) begin e0 = 1'b1; s0 = s; end
                else if (!e1) begin e1 = 1'b1; s1 = s; end
            end
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin : model_update
        logic e0, e1;
        int s0, s1;
        logic [3:0] acc;
        logic [PREG_W-1:0] tmp;
        if (!reset_n || rob_state == ROB_ROLLBACK) begin
            for (int i = 0; i < 4; i++) sq[i].delete();
            m_rr = 0;
        end else begin
            m_grants(e0, s0, e1, s1);
            for (int i = 0; i < 4; i++) acc[i] = src_valid[i] && (sq[i].size() != FIFO_DEPTH);
            if (e0) tmp = sq[s0].pop_front();
            if (e1) tmp = sq[s1].pop_front();
            for (int i = 0; i < 4; i++)
                if (acc[i]) sq[i].push_back(src_prd[i*PREG_W +: PREG_W]);
            if (e1) m_rr = (s1 + 1) % 4;
            else if (e0) m_rr = (s0 + 1) % 4;
        end
    end

    always @(negedge clock) begin : model_compare
        logic e0, e1;
        int s0, s1, pend;
        logic [PREG_W-1:0] r0, r1;
        logic [3:0] rdy;
        m_grants(e0, s0, e1, s1);
        r0 = e0 ? sq[s0][0] : '0;
        r1 = e1 ? sq[s1][0] : '0;
        pend = 0;
        for (int i = 0; i < 4; i++) begin
            rdy[i] = (rob_state != ROB_ROLLBACK) && (sq[i].size() != FIFO_DEPTH);
            pend += sq[i].size();
        end
        checks++;
        if (free0_en !== e0) begin failures++; $display("FAIL sb_free0_en got=%0b exp=%0b t=%0t", free0_en, e0, $time); end
        checks++;
        if (free0_rd !== r0) begin failures++; $display("FAIL sb_free0_rd got=%0h exp=%0h t=%0t", free0_rd, r0, $time); end
        checks++;
        if (free1_en !== e1) begin failures++; $display("FAIL sb_free1_en got=%0b exp=%0b t=%0t", free1_en, e1, $time); end
        checks++;
        if (free1_rd !== r1) begin failures++; $display("FAIL sb_free1_rd got=%0h exp=%0h t=%0t", free1_rd, r1, $time); end
        checks++;
        if (src_ready !== rdy) begin failures++; $display("FAIL sb_src_ready got=%b exp=%b t=%0t", src_ready, rdy, $time); end
        checks++;
        if (pending_cnt !== PEND_W'(pend)) begin failures++; $display("FAIL sb_pending got=%0d exp=%0d t=%0t", pending_cnt, pend, $time); end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_prd(input int i, input logic [PREG_W-1:0] v);
        src_prd[i*PREG_W +: PREG_W] = v;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (free0_en !== 1'b0 || free1_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b%b exp=00", free0_en, free1_en); end
        checks++;
        if (free0_rd !== '0 || free1_rd !== '0) begin failures++; $display("FAIL reset_rd got=%0h/%0h exp=0/0", free0_rd, free1_rd); end
        checks++;
        if (src_ready !== 4'b1111) begin failures++; $display("FAIL reset_ready got=%b exp=1111", src_ready); end
        checks++;
        if (pending_cnt !== '0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        src_valid = 4'b0100; set_prd(2, 6'h15);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b1 || free0_rd !== 6'h15 || free1_en !== 1'b0) begin
            failures++; $display("FAIL single_grant got=%b/%0h/%b exp=1/15/0", free0_en, free0_rd, free1_en);
        end
        tick();
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b0 || free1_en !== 1'b0) begin failures++; $display("FAIL single_idle got=%b%b exp=00", free0_en, free1_en); end
        // rr_ptr should now be 3: with sources 0 and 3 both loaded, 3 wins port 0.
        tick();
        src_valid = 4'b1001; set_prd(0, 6'h01); set_prd(3, 6'h03);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_rd !== 6'h03 || free1_rd !== 6'h01) begin failures++; $display("FAIL rr_after_single got=%0h/%0h exp=3/1", free0_rd, free1_rd); end
        tick();
        src_valid = 4'b1000; set_prd(3, 6'h04);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b1 || free0_rd !== 6'h04 || free1_en !== 1'b0) begin
            failures++; $display("FAIL rr_realign got=%b/%0h/%b exp=1/4/0", free0_en, free0_rd, free1_en);
        end
    endtask

    task automatic test_all_four();
        tick();
        src_valid = 4'b1111;
        set_prd(0, 6'd1); set_prd(1, 6'd2); set_prd(2, 6'd3); set_prd(3, 6'd4);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_rd !== 6'd1 || free1_rd !== 6'd2 || !free0_en || !free1_en || pending_cnt !== 4'd4) begin
            failures++; $display("FAIL all4_first got=%0d/%0d pend=%0d exp=1/2 pend=4", free0_rd, free1_rd, pending_cnt);
        end
        tick();
        @(negedge clock);
        checks++;
        if (free0_rd !== 6'd3 || free1_rd !== 6'd4 || pending_cnt !== 4'd2) begin
            failures++; $display("FAIL all4_second got=%0d/%0d pend=%0d exp=3/4 pend=2", free0_rd, free1_rd, pending_cnt);
        end
        tick();
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b0 || pending_cnt !== '0) begin failures++; $display("FAIL all4_drained en=%b pend=%0d exp=0/0", free0_en, pending_cnt); end
        tick();
        src_valid = 4'b1001; set_prd(0, 6'h05); set_prd(3, 6'h06);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_rd !== 6'h05 || free1_rd !== 6'h06) begin failures++; $display("FAIL all4_rr0 got=%0h/%0h exp=5/6", free0_rd, free1_rd); end
    endtask

    task automatic test_stream();
        int k [4];
        logic [PREG_W-1:0] seen [$];
        int frees = 0;
        int cyc = 0;
        logic saw_not_ready = 1'b0;
        for (int i = 0; i < 4; i++) k[i] = 0;
        while ((k[0] < 8 || k[1] < 8 || k[2] < 8 || k[3] < 8) && cyc < 200) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                src_valid[i] = (k[i] < 8);
                set_prd(i, 6'(16 + 8*i + k[i]));
            end
            @(negedge clock);
            if (free0_en) begin frees++; if (free0_rd >= 6'h10 && free0_rd <= 6'h17) seen.push_back(free0_rd); end
            if (free1_en) begin frees++; if (free1_rd >= 6'h10 && free1_rd <= 6'h17) seen.push_back(free1_rd); end
            if (src_ready != 4'b1111) saw_not_ready = 1'b1;
            for (int i = 0; i < 4; i++) if (src_valid[i] && src_ready[i]) k[i]++;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin failures++; $display("FAIL stream_budget cycles=%0d limit=200", cyc); end
        tick();
        src_valid = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (free0_en) begin frees++; if (free0_rd >= 6'h10 && free0_rd <= 6'h17) seen.push_back(free0_rd); end
            if (free1_en) begin frees++; if (free1_rd >= 6'h10 && free1_rd <= 6'h17) seen.push_back(free1_rd); end
            tick();
        end
        checks++;
        if (frees != 32) begin failures++; $display("FAIL stream_total got=%0d exp=32", frees); end
        checks++;
        if (seen.size() != 8) begin failures++; $display("FAIL stream_src0_count got=%0d exp=8", seen.size()); end
        for (int j = 0; j < seen.size() && j < 8; j++) begin
            checks++;
            if (seen[j] !== 6'(16 + j)) begin failures++; $display("FAIL stream_src0_order idx=%0d got=%0h exp=%0h", j, seen[j], 16 + j); end
        end
        checks++;
        if (!saw_not_ready) begin failures++; $display("FAIL stream_backpressure got=never_low exp=low_at_least_once"); end
    endtask

    task automatic test_rollback();
        tick();
        src_valid = 4'b1111;
        set_prd(0, 6'h31); set_prd(1, 6'h32); set_prd(2, 6'h33); set_prd(3, 6'h34);
        tick();
        src_valid = 4'b0111;
        set_prd(0, 6'h35); set_prd(1, 6'h36); set_prd(2, 6'h37);
        tick();
        rob_state = ROB_ROLLBACK;
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_prd(i, 6'h3C);
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b0 || free1_en !== 1'b0 || src_ready !== 4'b0000 || pending_cnt !== 4'd5) begin
            failures++; $display("FAIL rb_cycle en=%b%b ready=%b pend=%0d exp=00/0000/5", free0_en, free1_en, src_ready, pending_cnt);
        end
        tick();
        rob_state = ROB_IDLE;
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (pending_cnt !== '0 || src_ready !== 4'b1111) begin
            failures++; $display("FAIL rb_after pend=%0d ready=%b exp=0/1111", pending_cnt, src_ready);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (free0_en !== 1'b0 || free1_en !== 1'b0) begin failures++; $display("FAIL rb_stale cyc=%0d en=%b%b exp=00", c, free0_en, free1_en); end
            tick();
            @(negedge clock);
        end
    endtask

    task automatic test_async_reset();
        tick();
        src_valid = 4'b0111;
        set_prd(0, 6'h21); set_prd(1, 6'h22); set_prd(2, 6'h23);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (pending_cnt !== 4'd3 || free0_en !== 1'b1) begin failures++; $display("FAIL arst_pre pend=%0d en0=%b exp=3/1", pending_cnt, free0_en); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (free0_en !== 1'b0 || free1_en !== 1'b0 || pending_cnt !== '0 || src_ready !== 4'b1111) begin
            failures++; $display("FAIL arst_now en=%b%b pend=%0d ready=%b exp=00/0/1111", free0_en, free1_en, pending_cnt, src_ready);
        end
        tick();
        reset_n = 1'b1;
        tick();
        src_valid = 4'b0010; set_prd(1, 6'h2A);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b1 || free0_rd !== 6'h2A || free1_en !== 1'b0) begin
            failures++; $display("FAIL arst_first got=%b/%0h/%b exp=1/2a/0", free0_en, free0_rd, free1_en);
        end
    endtask

    task automatic test_src3_only();
        tick();
        rob_state = ROB_WALK;
        src_valid = 4'b1000; set_prd(3, 6'h3A);
        tick();
        set_prd(3, 6'h3B);
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b1 || free0_rd !== 6'h3A || free1_en !== 1'b0) begin
            failures++; $display("FAIL src3_first got=%b/%0h/%b exp=1/3a/0", free0_en, free0_rd, free1_en);
        end
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b1 || free0_rd !== 6'h3B || free1_en !== 1'b0) begin
            failures++; $display("FAIL src3_second got=%b/%0h/%b exp=1/3b/0", free0_en, free0_rd, free1_en);
        end
        tick();
        @(negedge clock);
        checks++;
        if (free0_en !== 1'b0) begin failures++; $display("FAIL src3_done en0=%b exp=0", free0_en); end
        tick();
        src_valid = 4'b1001; set_prd(0, 6'h01); set_prd(3, 6'h02);
        tick();
        src_valid = 4'b0000;
        @(negedge clock);
        checks++;
        if (free0_rd !== 6'h01 || free1_rd !== 6'h02) begin failures++; $display("FAIL src3_rr0 got=%0h/%0h exp=1/2", free0_rd, free1_rd); end
        rob_state = ROB_IDLE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        src_valid = 4'b0000;
        src_prd   = '0;
        rob_state = ROB_IDLE;
        test_reset();
        test_single();
        test_all_four();
        test_stream();
        test_rollback();
        test_async_reset();
        test_src3_only();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
